// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file initiator and its ALU.
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_ADDI = 3'b110,
    OP_LI   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;
endpackage

// File: rtl/regfile_ctrl_alu.sv
// Combinational ALU shared by the multicycle controller and the pipelined datapath.
module rf_alu
  import regfile_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  op_t                  op_i,
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  input  logic [DATAWIDTH-1:0] imm_i,
  output logic [DATAWIDTH-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SLT:  result_o = {{(DATAWIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_ADDI: result_o = a_i + imm_i;
      OP_LI:   result_o = imm_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Multicycle initiator for the 32-entry register file: IDLE -> READ -> EXEC -> WB.
// Optional macro RF_ZERO_REG_EN makes register 0 a hardwired zero.
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [ADDR_W-1:0]    req_rs1,
  input  logic [ADDR_W-1:0]    req_rs2,
  input  logic [ADDR_W-1:0]    req_rd,
  input  logic [DATAWIDTH-1:0] req_imm,
  output logic [ADDR_W-1:0]    readReg1,
  output logic [ADDR_W-1:0]    readReg2,
  input  logic [DATAWIDTH-1:0] readData1,
  input  logic [DATAWIDTH-1:0] readData2,
  output logic [ADDR_W-1:0]    writeReg,
  output logic [DATAWIDTH-1:0] writeData,
  output logic                 write,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_data
);

  state_t                state_q, state_d;
  op_t                   op_q;
  logic [ADDR_W-1:0]     rs1_q, rs2_q, rd_q;
  logic [DATAWIDTH-1:0]  imm_q, result_q;
  logic [DATAWIDTH-1:0]  opa, opb, alu_res;
  logic                  hs, wr_ok;

  assign hs = req_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        op_q  <= op_t'(req_op);
        rs1_q <= req_rs1;
        rs2_q <= req_rs2;
        rd_q  <= req_rd;
        imm_q <= req_imm;
      end
      // readData is valid only in EXEC, one cycle after READ presented the addresses
      if (state_q == EXEC) result_q <= alu_res;
    end
  end

`ifdef RF_ZERO_REG_EN
  assign opa   = (rs1_q == '0) ? '0 : readData1;
  assign opb   = (rs2_q == '0) ? '0 : readData2;
  assign wr_ok = (rd_q != '0);
`else
  assign opa   = readData1;
  assign opb   = readData2;
  assign wr_ok = 1'b1;
`endif

  rf_alu #(.DATAWIDTH(DATAWIDTH)) u_alu (
    .op_i    (op_q),
    .a_i     (opa),
    .b_i     (opb),
    .imm_i   (imm_q),
    .result_o(alu_res)
  );

  assign req_ready = (state_q == IDLE);
  assign readReg1  = rs1_q;
  assign readReg2  = rs2_q;
  assign writeReg  = rd_q;
  assign writeData = result_q;
  assign rsp_data  = result_q;
  assign rsp_valid = (state_q == WB);
  assign write     = (state_q == WB) && wr_ok;

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Multicycle initiator for the 32-entry register file. It accepts one register-register or register-immediate operation per valid/ready handshake and drives the register file read ports. It waits out the file's one-cycle synchronous read latency, computes the result in a small ALU, and writes it back through the write port. It sits between the instruction-decode stage and the register file, and reports each completed result with a single-cycle pulse.

## Interface
Parameters:
- DATAWIDTH, 32, data width; must match the register file.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  operation request present.
- req_ready  out  1  high exactly while in IDLE.
- req_op  in  3  operation code (see Operation).
- req_rs1, req_rs2, req_rd  in  5 each  source and destination register indices.
- req_imm  in  DATAWIDTH  immediate operand.
- readReg1, readReg2  out  5 each  register file read addresses.
- readData1, readData2  in  DATAWIDTH  register file read data; valid one cycle after the address is sampled.
- writeReg  out  5  register file write address.
- writeData  out  DATAWIDTH  register file write data.
- write  out  1  register file write enable.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  DATAWIDTH  result; held until the next completion.

## Operation
- Request fields are latched on the handshake `req_valid && req_ready`.
- readReg1/2 are driven from the latched rs1/rs2 fields at all times.
- writeReg is driven from the latched rd field.
- writeData is driven from the result register.
- Opcodes:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: signed compare of A and B; result 1 or 0, zero-extended.
  - 110 ADDI: A + imm.
  - 111 LI: result = imm; read data ignored.
- A = readData1, B = readData2 unless stated otherwise.
- Arithmetic is modulo 2^DATAWIDTH; no overflow flag.
- State machine:
  - IDLE → READ on handshake.
  - READ → EXEC unconditionally; the register file samples the addresses at the end of READ.
  - EXEC → WB; the ALU result is registered at the end of EXEC.
  - WB → IDLE; write=1 and rsp_valid=1 for this cycle only.
- Every opcode takes the full path, including LI, so latency is fixed.
- req_valid outside IDLE is ignored; it is not queued.

## Timing
- Reset values:
  - state IDLE, req_ready 1.
  - latched fields 0, so readReg1/2 and writeReg are 0.
  - result 0, so writeData and rsp_data are 0.
  - write 0, rsp_valid 0.
- Latency, with the handshake in cycle 0:
  - cycle 1: READ.
  - cycle 2: EXEC; readData is valid.
  - cycle 3: WB; write and rsp_valid are high, and the write commits at the end of cycle 3.
  - cycle 4: req_ready is 1 again.
- Throughput: one operation per 4 cycles.
- Dependencies: a dependent operation accepted in cycle 4 reads in cycle 5, so it always sees the committed value. No bypass is required.
- Reset mid-operation:
  - Asserting resetn low forces IDLE immediately and deasserts write asynchronously.
  - The pending operation is dropped, and no partial write or rsp_valid pulse occurs.

## Configuration
- RF_ZERO_REG_EN:
  - Defined: register 0 is hardwired zero.
    - Any operand whose source index is 0 is forced to 0, regardless of readData.
    - In WB with rd=0, write stays 0; rsp_valid and rsp_data still report the result.
  - Undefined: register 0 is an ordinary register; it is read and written like any other.

## Structure
- Shared package regfile_pkg holds:
  - op_t enum (3-bit opcodes).
  - state_t enum (IDLE, READ, EXEC, WB).
  - constants ADDR_W = 5 and NUM_REGS = 32.
- Sub-module rf_alu: combinational, taking op, A, B and imm and producing result. It is reused later by the pipelined datapath.

## Test plan
All scenarios use a bench with a real register file attached to the regfile-side ports.
- Reset, then LI rd=3 imm=5 → cycle 3: write=1, writeReg=3, writeData=5, rsp_valid pulse, rsp_data=5.
- ADD rd=4 rs1=3 rs2=3 → 10; SUB rd=5 rs1=0 rs2=3 (reg0=0) → 0xFFFF_FFFB.
- SLT rd=6 rs1=5 rs2=3 → 1; SLT rd=7 rs1=3 rs2=5 → 0; ADDI rd=8 rs1=5 imm=5 → 0.
- req_valid held high continuously → req_ready low in cycles 1–3; second request accepted in cycle 4; a dependent read of rd returns the new value.
- resetn pulsed low during EXEC → write never asserted, no rsp_valid, req_ready=1 after reset, target register unchanged.
- LI rd=0 imm=7, then ADD rd=9 rs1=0 rs2=0:
  - With RF_ZERO_REG_EN: write stays 0 on the LI and rsp_data=0 on the ADD.
  - Without it: write=1 on the LI and rsp_data=14 on the ADD.
